md_unit: RTL

Multiply/divide unit for the pipelined MIPS core, sitting in the execute stage directly downstream of the register file: it consumes the two forwarded register operands (rs, rt values) of mult/multu/div/divu/mthi/mtlo and owns the HI/LO registers read by mfhi/mflo. Multi-cycle operations are modelled with a fixed-latency busy counter. The stall unit uses `Busy` and `Start` to hold later HI/LO-touching instructions in decode.

---
 rtl/md_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/md_unit.sv
// Multiply/divide unit for the MIPS execute stage: owns HI/LO and models
// mult/div latency with a busy down-counter. Results commit on the final busy edge.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic          wr_q, wr_d;

    logic [63:0] a_s, b_s, prod_s, prod_u;
    logic [31:0] ua, ub, ub_safe, uq, ur, sq, sr, dq, dr;

    // Signed division is done on magnitudes so 0x80000000 / -1 wraps to
    // 0x80000000 naturally; the divisor is forced nonzero to keep the
    // unused quotient well-defined when D2 == 0.
    always_comb begin
        a_s     = {{32{D1[31]}}, D1};
        b_s     = {{32{D2[31]}}, D2};
        prod_s  = a_s * b_s;
        prod_u  = {32'b0, D1} * {32'b0, D2};
        ua      = (MDOp[0] == 1'b0 && D1[31]) ? (~D1 + 32'd1) : D1;
        ub      = (MDOp[0] == 1'b0 && D2[31]) ? (~D2 + 32'd1) : D2;
        ub_safe = (ub == 32'd0) ? 32'd1 : ub;
        uq      = ua / ub_safe;
        ur      = ua % ub_safe;
        sq      = (D1[31] ^ D2[31]) ? (~uq + 32'd1) : uq;
        sr      = D1[31] ? (~ur + 32'd1) : ur;
        dq      = MDOp[0] ? uq : sq;
        dr      = MDOp[0] ? ur : sr;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        wr_d     = wr_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    case (MDOp)
                        3'b000, 3'b001: begin
                            state_d = RUN;
                            cnt_d   = CW'(MULT_CYCLES);
                            {res_hi_d, res_lo_d} = MDOp[0] ? prod_u : prod_s;
                            wr_d    = 1'b1;
                        end
                        3'b010, 3'b011: begin
                            state_d  = RUN;
                            cnt_d    = CW'(DIV_CYCLES);
                            res_hi_d = dr;
                            res_lo_d = dq;
                            wr_d     = (D2 != 32'd0);
                        end
                        3'b100:  hi_d = D1;
                        3'b101:  lo_d = D1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    if (wr_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            wr_q     <= wr_d;
        end
    end

    assign Busy = (state_q == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;
endmodule
